// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences a bistable-ring PUF evaluation.
// Takes one challenge request and runs NUM_EVALS reset/settle/sample rounds
// on that challenge. The sampled bits are majority-voted, and the voted bit
// and the ones count are returned over a valid/ready response handshake.
module puf_eval_ctrl #(
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned NUM_EVALS     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_length,
    input  logic [127:0] req_challenge,
    output logic         puf_reset,
    output logic [1:0]   puf_length,
    output logic [127:0] puf_c,
    input  logic         puf_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_bit,
    output logic [3:0]   rsp_ones,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The timers count down to zero, so each phase loads its length minus one.
    // The EVAL phase lasts SETTLE_CYCLES+2 cycles, which covers the two
    // cycles of synchronizer delay before the sample is taken.
    localparam logic [15:0] RST_LOAD  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] EVAL_LOAD = 16'(SETTLE_CYCLES + 1);
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_EVALS - 1);
    localparam logic [3:0]  HALF      = 4'(NUM_EVALS / 2);

    state_t        state_r;
    state_t        state_nx_s;
    logic [15:0]   timer_r;
    logic [15:0]   timer_nx_s;
    logic [3:0]    eval_idx_r;
    logic [3:0]    eval_idx_nx_s;
    logic [3:0]    ones_r;
    logic [3:0]    ones_nx_s;
    logic          accept_s;
    logic          finish_s;
    logic          sync_meta_r;
    logic          sync_q_r;

    logic          req_ready_r;
    logic          puf_reset_r;
    logic [1:0]    puf_length_r;
    logic [127:0]  puf_c_r;
    logic          rsp_valid_r;
    logic          rsp_bit_r;
    logic [3:0]    rsp_ones_r;
    logic          busy_r;

    // Majority vote: the response is 1 when more than half the samples are 1.
    function automatic logic majority(input logic [3:0] ones);
        return (ones > HALF);
    endfunction

    // Two-flop synchronizer for the asynchronous PUF response.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_r <= 1'b0;
            sync_q_r    <= 1'b0;
        end else begin
            sync_meta_r <= puf_out;
            sync_q_r    <= sync_meta_r;
        end
    end

    // Next-state logic for the FSM, the phase timer, the evaluation index and the ones count.
    always_comb begin
        state_nx_s    = state_r;
        timer_nx_s    = timer_r;
        eval_idx_nx_s = eval_idx_r;
        ones_nx_s     = ones_r;
        accept_s      = 1'b0;
        finish_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s      = 1'b1;
                    state_nx_s    = ST_RST;
                    timer_nx_s    = RST_LOAD;
                    eval_idx_nx_s = 4'd0;
                    ones_nx_s     = 4'd0;
                end else begin
                    state_nx_s    = ST_IDLE;
                end
            end
            ST_RST: begin
                if (timer_r == 16'd0) begin
                    state_nx_s = ST_EVAL;
                    timer_nx_s = EVAL_LOAD;
                end else begin
                    timer_nx_s = timer_r - 16'd1;
                end
            end
            ST_EVAL: begin
                if (timer_r == 16'd0) begin
                    ones_nx_s     = ones_r + {3'b000, sync_q_r};
                    eval_idx_nx_s = eval_idx_r + 4'd1;
                    if (eval_idx_r == LAST_IDX) begin
                        state_nx_s = ST_DONE;
                        timer_nx_s = 16'd0;
                        finish_s   = 1'b1;
                    end else begin
                        state_nx_s = ST_RST;
                        timer_nx_s = RST_LOAD;
                    end
                end else begin
                    timer_nx_s = timer_r - 16'd1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered-output update. The outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            timer_r      <= 16'd0;
            eval_idx_r   <= 4'd0;
            ones_r       <= 4'd0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            puf_reset_r  <= 1'b1;
            puf_length_r <= 2'd0;
            puf_c_r      <= 128'd0;
            rsp_valid_r  <= 1'b0;
            rsp_bit_r    <= 1'b0;
            rsp_ones_r   <= 4'd0;
        end else begin
            state_r     <= state_nx_s;
            timer_r     <= timer_nx_s;
            eval_idx_r  <= eval_idx_nx_s;
            ones_r      <= ones_nx_s;
            req_ready_r <= (state_nx_s == ST_IDLE);
            busy_r      <= (state_nx_s != ST_IDLE);
            puf_reset_r <= (state_nx_s != ST_EVAL);
            rsp_valid_r <= (state_nx_s == ST_DONE);
            if (accept_s) begin
                puf_length_r <= req_length;
                puf_c_r      <= req_challenge;
            end
            if (finish_s) begin
                rsp_ones_r <= ones_nx_s;
                rsp_bit_r  <= majority(ones_nx_s);
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign busy       = busy_r;
    assign puf_reset  = puf_reset_r;
    assign puf_length = puf_length_r;
    assign puf_c      = puf_c_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_bit    = rsp_bit_r;
    assign rsp_ones   = rsp_ones_r;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Testbench for puf_eval_ctrl. It runs a default-parameter instance and a
// minimal instance (1 eval, 1 reset cycle, 1 settle cycle). Expected
// responses go into scoreboard queues, and negedge monitors compare them.
module tb_puf_eval_ctrl;

    localparam int R   = 4;
    localparam int S   = 16;
    localparam int N   = 5;
    localparam int P   = R + S + 2;
    localparam int LAT = N * P;
    localparam int LB  = 1 * (1 + 1 + 2);

    typedef struct packed {
        logic       b;
        logic [3:0] ones;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         req_valid, req_ready, puf_reset, puf_out, rsp_valid, rsp_ready, rsp_bit, busy;
    logic [1:0]   req_length, puf_length;
    logic [127:0] req_challenge, puf_c;
    logic [3:0]   rsp_ones;

    logic         req_valid_b, req_ready_b, puf_reset_b, puf_out_b, rsp_valid_b, rsp_ready_b, rsp_bit_b, busy_b;
    logic [1:0]   req_length_b, puf_length_b;
    logic [127:0] req_challenge_b, puf_c_b;
    logic [3:0]   rsp_ones_b;

    int n_assert = 0;
    int n_fail   = 0;
    rsp_t exp_q[$];
    rsp_t exp_qb[$];

    puf_eval_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_length(req_length), .req_challenge(req_challenge), .puf_reset(puf_reset),
        .puf_length(puf_length), .puf_c(puf_c), .puf_out(puf_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_bit(rsp_bit), .rsp_ones(rsp_ones), .busy(busy)
    );

    puf_eval_ctrl #(.RESET_CYCLES(1), .SETTLE_CYCLES(1), .NUM_EVALS(1)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_length(req_length_b), .req_challenge(req_challenge_b), .puf_reset(puf_reset_b),
        .puf_length(puf_length_b), .puf_c(puf_c_b), .puf_out(puf_out_b), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready_b), .rsp_bit(rsp_bit_b), .rsp_ones(rsp_ones_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: count the sampled ones and vote by strict majority.
    function automatic rsp_t model(input logic [14:0] vals, input int n);
        int c;
        rsp_t r;
        c = 0;
        for (int i = 0; i < n; i++) c += int'(vals[i]);
        r.ones = 4'(c);
        r.b    = (c > n / 2);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the default instance: compares each response handshake against the queue.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_bit", {127'd0, rsp_bit}, {127'd0, e.b});
                check("rsp_ones", {124'd0, rsp_ones}, {124'd0, e.ones});
            end
        end
    end

    // Monitor for the minimal instance.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset && rsp_valid_b && rsp_ready_b) begin
            if (exp_qb.size() == 0) begin
                check("rsp_b_unexpected", 128'd1, 128'd0);
            end else begin
                e = exp_qb.pop_front();
                check("rsp_b_bit", {127'd0, rsp_bit_b}, {127'd0, e.b});
                check("rsp_b_ones", {124'd0, rsp_ones_b}, {124'd0, e.ones});
            end
        end
    end

    // Present a request to an idle DUT and check that it is accepted on the next edge.
    task automatic issue(input logic [127:0] ch, input logic [1:0] len, input logic [14:0] vals, input bit push);
        req_valid     = 1'b1;
        req_challenge = ch;
        req_length    = len;
        if (push) exp_q.push_back(model(vals, N));
        tick();
        req_valid = 1'b0;
        check("accept_busy", {127'd0, busy}, 128'd1);
        check("accept_req_ready", {127'd0, req_ready}, 128'd0);
        check("puf_c_latched", puf_c, ch);
        check("puf_length_latched", {126'd0, puf_length}, {126'd0, len});
    endtask

    // Run the evaluation windows: drive puf_out per window, check the puf_reset pattern,
    // and scramble the request inputs, which must have no effect while busy.
    task automatic body(input logic [127:0] ch, input logic [1:0] len, input logic [14:0] vals);
        for (int i = 0; i < LAT; i++) begin
            if (i % P == 0) puf_out = vals[i / P];
            check("puf_reset_phase", {127'd0, puf_reset}, {127'd0, ((i % P) < R)});
            check("rsp_valid_early", {127'd0, rsp_valid}, 128'd0);
            req_challenge = rand128();
            req_length    = 2'($urandom());
            req_valid     = 1'($urandom());
            tick();
        end
        req_valid = 1'b0;
        check("rsp_valid_latency", {127'd0, rsp_valid}, 128'd1);
        check("puf_c_hold", puf_c, ch);
        check("puf_length_hold", {126'd0, puf_length}, {126'd0, len});
    endtask

    // Apply bp cycles of backpressure, then complete the response handshake.
    task automatic finish_rsp(input int bp, input rsp_t e, input logic [127:0] ch);
        rsp_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            check("bp_rsp_valid", {127'd0, rsp_valid}, 128'd1);
            check("bp_rsp_bit", {127'd0, rsp_bit}, {127'd0, e.b});
            check("bp_rsp_ones", {124'd0, rsp_ones}, {124'd0, e.ones});
            check("bp_req_ready", {127'd0, req_ready}, 128'd0);
            check("bp_busy", {127'd0, busy}, 128'd1);
            check("bp_puf_c", puf_c, ch);
            req_valid     = (i % 3 == 1);
            req_challenge = rand128();
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        check("post_req_ready", {127'd0, req_ready}, 128'd1);
        check("post_busy", {127'd0, busy}, 128'd0);
        check("post_rsp_bit_hold", {127'd0, rsp_bit}, {127'd0, e.b});
        check("post_rsp_ones_hold", {124'd0, rsp_ones}, {124'd0, e.ones});
        check("post_puf_c_hold", puf_c, ch);
    endtask

    task automatic full_req(input logic [127:0] ch, input logic [1:0] len, input logic [14:0] vals, input int bp);
        issue(ch, len, vals, 1'b1);
        body(ch, len, vals);
        finish_rsp(bp, model(vals, N), ch);
    endtask

    initial begin
        logic [127:0] c1, c2;
        logic [14:0]  v;
        rsp_t         e;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; puf_out = 1'b1;
        req_length = 2'd0; req_challenge = 128'd0;
        req_valid_b = 1'b0; rsp_ready_b = 1'b0; puf_out_b = 1'b0;
        req_length_b = 2'd0; req_challenge_b = 128'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_puf_reset", {127'd0, puf_reset}, 128'd1);
        check("rst_puf_length", {126'd0, puf_length}, 128'd0);
        check("rst_puf_c", puf_c, 128'd0);
        check("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        check("rst_rsp_bit", {127'd0, rsp_bit}, 128'd0);
        check("rst_rsp_ones", {124'd0, rsp_ones}, 128'd0);
        check("rst_req_ready", {127'd0, req_ready}, 128'd1);
        check("rst_busy", {127'd0, busy}, 128'd0);
        tick();

        // All-ones PUF output with the A5 challenge.
        c1 = {16{8'hA5}};
        full_req(c1, 2'b01, 15'h7FFF, 0);
        // Alternating samples: 1,0,1,0,0 then 1,1,0,1,0.
        full_req(rand128(), 2'b00, 15'b000_0000_0000_0101, 1);
        full_req(rand128(), 2'b10, 15'b000_0000_0000_1011, 0);
        // Backpressure for 20 cycles.
        full_req(rand128(), 2'b11, 15'b000_0000_0001_0110, 20);

        // Reset during the EVAL phase of evaluation 3.
        c1 = rand128();
        issue(c1, 2'b01, 15'h7FFF, 1'b0);
        for (int i = 0; i < 2 * P + R + 10; i++) begin
            if (i % P == 0) puf_out = 1'b1;
            tick();
        end
        check("pre_abort_puf_reset", {127'd0, puf_reset}, 128'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_puf_reset", {127'd0, puf_reset}, 128'd1);
        check("abort_puf_c", puf_c, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_req_ready", {127'd0, req_ready}, 128'd1);
        for (int i = 0; i < LAT + 10; i++) begin
            check("abort_no_rsp", {127'd0, rsp_valid}, 128'd0);
            tick();
        end
        full_req(rand128(), 2'b10, 15'b000_0000_0001_1001, 2);

        // Back-to-back: new request held during the DONE handshake.
        c1 = rand128();
        c2 = rand128();
        v  = 15'b000_0000_0001_1100;
        issue(c1, 2'b01, v, 1'b1);
        body(c1, 2'b01, v);
        e = model(v, N);
        rsp_ready     = 1'b1;
        req_valid     = 1'b1;
        req_challenge = c2;
        req_length    = 2'b10;
        tick();
        rsp_ready = 1'b0;
        check("b2b_not_accepted_busy", {127'd0, busy}, 128'd0);
        check("b2b_req_ready", {127'd0, req_ready}, 128'd1);
        check("b2b_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        check("b2b_puf_c_old", puf_c, c1);
        check("b2b_rsp_ones_hold", {124'd0, rsp_ones}, {124'd0, e.ones});
        v = 15'b000_0000_0000_0011;
        issue(c2, 2'b10, v, 1'b1);
        body(c2, 2'b10, v);
        finish_rsp(0, model(v, N), c2);

        // Randomized requests.
        for (int k = 0; k < 6; k++) begin
            v  = 15'($urandom_range(0, 31));
            c1 = rand128();
            full_req(c1, 2'($urandom()), v, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Minimal instance: 4-cycle latency, and the response equals the sampled bit.
        for (int k = 0; k < 2; k++) begin
            puf_out_b       = k[0];
            req_valid_b     = 1'b1;
            req_length_b    = 2'b11;
            c1              = rand128();
            req_challenge_b = c1;
            e.b    = k[0];
            e.ones = {3'b000, k[0]};
            exp_qb.push_back(e);
            tick();
            req_valid_b = 1'b0;
            check("b_puf_length", {126'd0, puf_length_b}, 128'd3);
            check("b_puf_c", puf_c_b, c1);
            check("b_busy", {127'd0, busy_b}, 128'd1);
            for (int i = 0; i < LB; i++) begin
                check("b_puf_reset_phase", {127'd0, puf_reset_b}, {127'd0, (i < 1)});
                check("b_rsp_valid_early", {127'd0, rsp_valid_b}, 128'd0);
                tick();
            end
            check("b_rsp_valid_latency", {127'd0, rsp_valid_b}, 128'd1);
            rsp_ready_b = 1'b1;
            tick();
            rsp_ready_b = 1'b0;
            check("b_post_rsp_valid", {127'd0, rsp_valid_b}, 128'd0);
            check("b_post_req_ready", {127'd0, req_ready_b}, 128'd1);
            tick();
        end

        tick();
        tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        check("scoreboard_b_drained", 128'(exp_qb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
